// File: rtl/mac_pkg.sv
// Shared types and default widths for the mac unit and its downstream stages.
package mac_pkg;

    localparam int unsigned MAC_OUT_WIDTH = 4;
    localparam int unsigned MAC_ACC_WIDTH = 8;

    typedef enum logic {
        ACCUM,
        HOLD
    } mac_state_e;

endpackage

// File: rtl/mac_sat_add.sv
// Combinational unsigned adder that clamps to all-ones on carry-out.
module mac_sat_add #(
    parameter int unsigned ACC_WIDTH = 8
) (
    input  logic [ACC_WIDTH-1:0] a,
    input  logic [ACC_WIDTH-1:0] b,
    output logic [ACC_WIDTH-1:0] sum,
    output logic                 sat
);

    logic [ACC_WIDTH:0] wide;

    always_comb begin
        wide = {1'b0, a} + {1'b0, b};
        sat  = wide[ACC_WIDTH];
        sum  = sat ? {ACC_WIDTH{1'b1}} : wide[ACC_WIDTH-1:0];
    end

endmodule

// File: rtl/mac_dot_accum.sv
// Sums VEC_LEN mac results into a saturating dot-product total and holds it on a
// valid/ready port, stalling the input side until the total is taken.
module mac_dot_accum
    import mac_pkg::*;
#(
    parameter int unsigned OUT_WIDTH = MAC_OUT_WIDTH,
    parameter int unsigned ACC_WIDTH = MAC_ACC_WIDTH,
    parameter int unsigned VEC_LEN   = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic [OUT_WIDTH-1:0] in_data,
    output logic                 in_ready,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_WIDTH-1:0] out_data,
    output logic                 out_sat
);

    // Keep a 1-bit counter for VEC_LEN=1; it then never leaves zero.
    localparam int unsigned CNT_WIDTH = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(VEC_LEN - 1);

    mac_state_e           state_q;
    logic [ACC_WIDTH-1:0] acc_q;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic                 sat_q;

    logic [ACC_WIDTH-1:0] in_ext;
    logic [ACC_WIDTH-1:0] add_sum;
    logic                 add_sat;

    assign in_ext = ACC_WIDTH'(in_data);

    mac_sat_add #(
        .ACC_WIDTH(ACC_WIDTH)
    ) u_sat_add (
        .a  (acc_q),
        .b  (in_ext),
        .sum(add_sum),
        .sat(add_sat)
    );

    assign in_ready = reset && (state_q == ACCUM);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= ACCUM;
            acc_q     <= '0;
            cnt_q     <= '0;
            sat_q     <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sat   <= 1'b0;
        end else begin
            case (state_q)
                ACCUM: begin
                    if (flush) begin
                        // Flush beats a same-cycle beat even though in_ready is high.
                        acc_q <= '0;
                        cnt_q <= '0;
                        sat_q <= 1'b0;
                    end else if (in_valid) begin
                        if (cnt_q == CNT_LAST) begin
                            out_data  <= add_sum;
                            out_sat   <= sat_q | add_sat;
                            out_valid <= 1'b1;
                            state_q   <= HOLD;
                            acc_q     <= '0;
                            cnt_q     <= '0;
                            sat_q     <= 1'b0;
                        end else begin
                            acc_q <= add_sum;
                            sat_q <= sat_q | add_sat;
                            cnt_q <= cnt_q + CNT_WIDTH'(1);
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state_q   <= ACCUM;
                    end
                end
                default: state_q <= ACCUM;
            endcase
        end
    end

endmodule

// File: tb/tb_mac_dot_accum.sv
// Directed bench for mac_dot_accum: default, narrow-accumulator and single-beat builds.
module tb_mac_dot_accum;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    // d0: defaults (VEC_LEN=4, ACC_WIDTH=8)
    logic       a_valid, a_ready, a_flush, a_ovalid, a_oready, a_osat;
    logic [3:0] a_data;
    logic [7:0] a_odata;
    // d1: ACC_WIDTH=5
    logic       b_valid, b_ready, b_flush, b_ovalid, b_oready, b_osat;
    logic [3:0] b_data;
    logic [4:0] b_odata;
    // d2: VEC_LEN=1
    logic       c_valid, c_ready, c_flush, c_ovalid, c_oready, c_osat;
    logic [3:0] c_data;
    logic [7:0] c_odata;

    int nchecks = 0;
    int nerrors = 0;

    mac_dot_accum u_d0 (
        .clk(clk), .reset(reset), .in_valid(a_valid), .in_data(a_data), .in_ready(a_ready),
        .flush(a_flush), .out_valid(a_ovalid), .out_ready(a_oready), .out_data(a_odata),
        .out_sat(a_osat)
    );

    mac_dot_accum #(
        .ACC_WIDTH(5)
    ) u_d1 (
        .clk(clk), .reset(reset), .in_valid(b_valid), .in_data(b_data), .in_ready(b_ready),
        .flush(b_flush), .out_valid(b_ovalid), .out_ready(b_oready), .out_data(b_odata),
        .out_sat(b_osat)
    );

    mac_dot_accum #(
        .VEC_LEN(1)
    ) u_d2 (
        .clk(clk), .reset(reset), .in_valid(c_valid), .in_data(c_data), .in_ready(c_ready),
        .flush(c_flush), .out_valid(c_ovalid), .out_ready(c_oready), .out_data(c_odata),
        .out_sat(c_osat)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchecks++;
        if (got !== exp) begin
            nerrors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Outputs are sampled 1 time unit after the edge; inputs change at the same point.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic feed_a(input logic [3:0] v);
        a_valid = 1'b1;
        a_data  = v;
        tick();
        a_valid = 1'b0;
    endtask

    task automatic feed_b(input logic [3:0] v);
        b_valid = 1'b1;
        b_data  = v;
        tick();
        b_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        {a_valid, a_flush, a_oready, a_data} = '0;
        {b_valid, b_flush, b_data} = '0;
        {c_valid, c_flush, c_data} = '0;
        b_oready = 1'b1;
        c_oready = 1'b1;
        tick();
        tick();
        check("rst_ovalid", a_ovalid, 0);
        check("rst_odata", a_odata, 0);
        check("rst_osat", a_osat, 0);
        check("rst_inready_low", a_ready, 0);
        reset = 1'b1;
        #1;
        check("inready_after_rst", a_ready, 1);

        // Basic vector: 6+3+2+12 = 23
        a_oready = 1'b1;
        feed_a(4'd6);
        feed_a(4'd3);
        feed_a(4'd2);
        check("basic_no_early_valid", a_ovalid, 0);
        feed_a(4'd12);
        check("basic_ovalid", a_ovalid, 1);
        check("basic_odata", a_odata, 23);
        check("basic_osat", a_osat, 0);
        check("basic_hold_inready", a_ready, 0);
        tick();
        check("basic_valid_one_cycle", a_ovalid, 0);
        check("basic_inready_back", a_ready, 1);
        feed_a(4'd1);
        feed_a(4'd1);
        feed_a(4'd1);
        feed_a(4'd1);
        check("basic_restart_odata", a_odata, 4);
        tick();

        // Backpressure
        a_oready = 1'b0;
        feed_a(4'd6);
        feed_a(4'd3);
        feed_a(4'd2);
        feed_a(4'd12);
        a_valid = 1'b1;
        a_data  = 4'd5;
        for (int i = 0; i < 3; i++) begin
            check("bp_inready", a_ready, 0);
            check("bp_ovalid", a_ovalid, 1);
            check("bp_odata", a_odata, 23);
            tick();
        end
        a_oready = 1'b1;
        tick();
        check("bp_handshake_ovalid", a_ovalid, 0);
        check("bp_handshake_inready", a_ready, 1);
        tick();
        tick();
        tick();
        check("bp_fives_not_early", a_ovalid, 0);
        tick();
        a_valid = 1'b0;
        check("bp_fives_ovalid", a_ovalid, 1);
        check("bp_fives_odata", a_odata, 20);
        tick();

        // Flush
        a_oready = 1'b0;
        feed_a(4'd7);
        feed_a(4'd7);
        a_flush = 1'b1;
        feed_a(4'd9);
        a_flush = 1'b0;
        feed_a(4'd1);
        feed_a(4'd1);
        feed_a(4'd1);
        check("flush_no_early_valid", a_ovalid, 0);
        feed_a(4'd1);
        check("flush_ovalid", a_ovalid, 1);
        check("flush_odata", a_odata, 4);
        a_flush = 1'b1;
        tick();
        a_flush = 1'b0;
        check("flush_in_hold_ovalid", a_ovalid, 1);
        check("flush_in_hold_odata", a_odata, 4);
        a_oready = 1'b1;
        tick();
        check("flush_done_ovalid", a_ovalid, 0);
        check("flush_keep_odata", a_odata, 4);

        // Reset mid-vector, then reset during HOLD
        a_oready = 1'b0;
        feed_a(4'd9);
        feed_a(4'd9);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        feed_a(4'd2);
        feed_a(4'd2);
        feed_a(4'd2);
        check("rstmid_no_early_valid", a_ovalid, 0);
        feed_a(4'd2);
        check("rstmid_ovalid", a_ovalid, 1);
        check("rstmid_odata", a_odata, 8);
        reset = 1'b0;
        tick();
        check("rsthold_ovalid", a_ovalid, 0);
        check("rsthold_odata", a_odata, 0);
        reset = 1'b1;
        a_oready = 1'b1;

        // Saturation with ACC_WIDTH=5
        feed_b(4'd15);
        feed_b(4'd15);
        feed_b(4'd15);
        feed_b(4'd15);
        check("sat_ovalid", b_ovalid, 1);
        check("sat_odata", b_odata, 31);
        check("sat_osat", b_osat, 1);
        tick();
        feed_b(4'd1);
        feed_b(4'd1);
        feed_b(4'd1);
        feed_b(4'd1);
        check("sat_next_odata", b_odata, 4);
        check("sat_next_osat", b_osat, 0);
        tick();

        // VEC_LEN=1
        check("v1_inready0", c_ready, 1);
        c_valid = 1'b1;
        c_data  = 4'd3;
        tick();
        check("v1_ovalid_a", c_ovalid, 1);
        check("v1_odata_a", c_odata, 3);
        check("v1_osat_a", c_osat, 0);
        check("v1_inready1", c_ready, 0);
        c_data = 4'd12;
        tick();
        check("v1_ovalid_gap", c_ovalid, 0);
        check("v1_inready2", c_ready, 1);
        tick();
        c_valid = 1'b0;
        check("v1_ovalid_b", c_ovalid, 1);
        check("v1_odata_b", c_odata, 12);
        tick();
        check("v1_done", c_ovalid, 0);

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

endmodule
